// File: rtl/rvne_inst_encoder.sv
// Instruction encoder: turns decoded command fields into 32-bit RISC-V-style words,
// buffers them in a small FIFO and streams them out with an auto-incrementing word address.
module rvne_inst_encoder #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_class,
  input  logic [2:0]  cmd_funct3,
  input  logic [4:0]  cmd_rd,
  input  logic [4:0]  cmd_rs1,
  input  logic [4:0]  cmd_rs2,
  input  logic [11:0] cmd_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_addr,
  output logic [31:0] out_data,
  input  logic        addr_load,
  input  logic [7:0]  addr_base,
  output logic        err_illegal,
  output logic [7:0]  err_count,
  output logic [2:0]  fifo_count
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  localparam logic [2:0] CLS_LOAD   = 3'b000;
  localparam logic [2:0] CLS_STORE  = 3'b001;
  localparam logic [2:0] CLS_NEURON = 3'b010;
  localparam logic [2:0] CLS_RTYPE  = 3'b011;
  localparam logic [2:0] CLS_BRANCH = 3'b100;
  localparam logic [2:0] CLS_ITYPE  = 3'b101;
  localparam logic [2:0] CLS_VLOAD  = 3'b110;
  localparam logic [2:0] CLS_NSR    = 3'b111;

  logic [31:0]   mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    addr_q, addr_d;
  logic [7:0]    err_count_q, err_count_d;
  logic          err_q, err_d;

  logic [6:0]    opcode;
  logic [31:0]   enc_word;
  logic          illegal;
  logic          accept, push, pop;
  logic [3:0]    count_ext;

  always_comb begin
    opcode   = 7'b0000000;
    enc_word = 32'h0;
    illegal  = 1'b0;
    case (cmd_class)
      CLS_LOAD:   opcode = 7'b0000011;
      CLS_STORE:  opcode = 7'b0100011;
      CLS_NEURON: opcode = 7'b0000001;
      CLS_RTYPE:  opcode = 7'b0110011;
      CLS_BRANCH: opcode = 7'b1100011;
      CLS_ITYPE:  opcode = 7'b0010011;
      CLS_VLOAD:  opcode = 7'b0000010;
      CLS_NSR:    opcode = 7'b0110010;
      default:    opcode = 7'b0000000;
    endcase
    case (cmd_class)
      CLS_LOAD, CLS_ITYPE, CLS_VLOAD:
        enc_word = {cmd_imm, cmd_rs1, cmd_funct3, cmd_rd, opcode};
      CLS_STORE:
        enc_word = {cmd_imm[11:5], cmd_rs2, cmd_rs1, cmd_funct3, cmd_imm[4:0], opcode};
      // cmd_imm carries offset[12:1], so imm[11] is the sign and imm[10] lands in bit 7
      CLS_BRANCH:
        enc_word = {cmd_imm[11], cmd_imm[9:4], cmd_rs2, cmd_rs1, cmd_funct3,
                    cmd_imm[3:0], cmd_imm[10], opcode};
      default:
        enc_word = {cmd_imm[11:5], cmd_rs2, cmd_rs1, cmd_funct3, cmd_rd, opcode};
    endcase
    if ((cmd_class == CLS_VLOAD) && (cmd_funct3[2:1] == 2'b11))
      illegal = 1'b1;
    if ((cmd_class == CLS_NEURON) && (cmd_funct3 > 3'b010))
      illegal = 1'b1;
  end

  assign cmd_ready = (count_q < CW'(FIFO_DEPTH));
  assign out_valid = (count_q != '0);
  assign accept    = cmd_valid & cmd_ready;
  assign push      = accept & ~illegal;
  assign pop       = out_valid & out_ready;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    addr_d      = addr_q;
    err_count_d = err_count_q;
    err_d       = accept & illegal;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    // a load wins over the pop increment; the pop itself still happens above
    if (addr_load)  addr_d = addr_base;
    else if (pop)   addr_d = addr_q + 8'd1;
    if (accept && illegal && (err_count_q != 8'hFF))
      err_count_d = err_count_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      addr_q      <= 8'h00;
      err_count_q <= 8'h00;
      err_q       <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      addr_q      <= addr_d;
      err_count_q <= err_count_d;
      err_q       <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= enc_word;
  end

  assign out_data    = mem_q[rd_ptr_q];
  assign out_addr    = addr_q;
  assign err_illegal = err_q;
  assign err_count   = err_count_q;
  assign count_ext   = 4'(count_q);
  assign fifo_count  = count_ext[3] ? 3'd7 : count_ext[2:0];

endmodule

// File: tb/tb_rvne_inst_encoder.sv
// Directed bench for rvne_inst_encoder: expected words/addresses go into a scoreboard
// queue at issue time; a monitor pops and compares on every output handshake.
module tb_rvne_inst_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready;
  logic [2:0]  cmd_class, cmd_funct3;
  logic [4:0]  cmd_rd, cmd_rs1, cmd_rs2;
  logic [11:0] cmd_imm;
  logic        out_valid, out_ready;
  logic [7:0]  out_addr;
  logic [31:0] out_data;
  logic        addr_load;
  logic [7:0]  addr_base;
  logic        err_illegal;
  logic [7:0]  err_count;
  logic [2:0]  fifo_count;

  typedef struct packed {
    logic [7:0]  addr;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  rvne_inst_encoder #(.FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_class(cmd_class), .cmd_funct3(cmd_funct3),
    .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2), .cmd_imm(cmd_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_data(out_data),
    .addr_load(addr_load), .addr_base(addr_base),
    .err_illegal(err_illegal), .err_count(err_count), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  // monitor: handshake is judged mid-cycle, it completes at the following rising edge
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", out_data, 32'hxxxxxxxx);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("out_data", out_data, e.data);
        check("out_addr", {24'h0, out_addr}, {24'h0, e.addr});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input logic [2:0] cls, input logic [2:0] f3, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [11:0] imm);
    cmd_class  = cls;
    cmd_funct3 = f3;
    cmd_rd     = rd;
    cmd_rs1    = rs1;
    cmd_rs2    = rs2;
    cmd_imm    = imm;
  endtask

  task automatic send(input logic [2:0] cls, input logic [2:0] f3, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [11:0] imm);
    set_cmd(cls, f3, rd, rs1, rs2, imm);
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 30) begin
      tick();
      n++;
    end
    check({name, "_drained"}, {31'h0, (exp_q.size() == 0 && !out_valid)}, 32'h1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_out_valid", {31'h0, out_valid}, 32'h0);
    check("rst_fifo_count", {29'h0, fifo_count}, 32'h0);
    check("rst_out_addr", {24'h0, out_addr}, 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; out_ready = 1'b0;
    addr_load = 1'b0; addr_base = 8'h00;
    set_cmd(3'd0, 3'd0, 5'd0, 5'd0, 5'd0, 12'h000);
    #1;
    check("reset_err_illegal", {31'h0, err_illegal}, 32'h0);
    check("reset_err_count", {24'h0, err_count}, 32'h0);
    check("reset_cmd_ready", {31'h0, cmd_ready}, 32'h1);
    do_reset();

    // ITYPE addi x1, x0, 5 into empty FIFO; then hold while stalled
    exp_q.push_back('{addr: 8'h00, data: 32'h00500093});
    send(3'b101, 3'b000, 5'd1, 5'd0, 5'd0, 12'h005);
    check("t1_out_valid", {31'h0, out_valid}, 32'h1);
    check("t1_out_data", out_data, 32'h00500093);
    check("t1_fifo_count", {29'h0, fifo_count}, 32'h1);
    tick();
    check("t1_hold_data", out_data, 32'h00500093);
    check("t1_hold_addr", {24'h0, out_addr}, 32'h0);
    out_ready = 1'b1;
    wait_drain("t1");

    // STORE then VLOAD back to back, streaming out
    do_reset();
    exp_q.push_back('{addr: 8'h00, data: 32'h00512423});
    exp_q.push_back('{addr: 8'h01, data: 32'h01019102});
    send(3'b001, 3'b010, 5'd0, 5'd2, 5'd5, 12'h008);
    send(3'b110, 3'b001, 5'd2, 5'd3, 5'd0, 12'h010);
    wait_drain("t2");

    // illegal NEURON, then NSR, BRANCH, LOAD; then illegal VLOAD
    send(3'b010, 3'b011, 5'd0, 5'd0, 5'd0, 12'h000);
    check("t3_err_pulse", {31'h0, err_illegal}, 32'h1);
    check("t3_err_count", {24'h0, err_count}, 32'h1);
    check("t3_no_push", {31'h0, out_valid}, 32'h0);
    exp_q.push_back('{addr: 8'h02, data: 32'h00209032});
    exp_q.push_back('{addr: 8'h03, data: 32'h862095E3});
    exp_q.push_back('{addr: 8'h04, data: 32'hFFF22183});
    send(3'b111, 3'b001, 5'd0, 5'd1, 5'd2, 12'h000);
    check("t3_err_cleared", {31'h0, err_illegal}, 32'h0);
    send(3'b100, 3'b001, 5'd0, 5'd1, 5'd2, 12'hC35);
    send(3'b000, 3'b010, 5'd3, 5'd4, 5'd0, 12'hFFF);
    wait_drain("t3");
    send(3'b110, 3'b110, 5'd1, 5'd1, 5'd0, 12'h001);
    check("t3_vload_err", {31'h0, err_illegal}, 32'h1);
    check("t3_err_count2", {24'h0, err_count}, 32'h2);
    tick();
    check("t3_vload_no_push", {31'h0, out_valid}, 32'h0);

    // fill to full with out_ready low, 5th waits for a pop
    do_reset();
    out_ready = 1'b0;
    exp_q.push_back('{addr: 8'h00, data: 32'h00100093});
    exp_q.push_back('{addr: 8'h01, data: 32'h00200113});
    exp_q.push_back('{addr: 8'h02, data: 32'h00300193});
    exp_q.push_back('{addr: 8'h03, data: 32'h00400213});
    exp_q.push_back('{addr: 8'h04, data: 32'h00500293});
    for (int i = 0; i < 4; i++) begin
      check("t4_ready_before", {31'h0, cmd_ready}, 32'h1);
      send(3'b101, 3'b000, 5'(i + 1), 5'd0, 5'd0, 12'(i + 1));
    end
    check("t4_full_ready", {31'h0, cmd_ready}, 32'h0);
    check("t4_full_count", {29'h0, fifo_count}, 32'h4);
    set_cmd(3'b101, 3'b000, 5'd5, 5'd0, 5'd0, 12'h005);
    cmd_valid = 1'b1;
    tick();
    check("t4_blocked_count", {29'h0, fifo_count}, 32'h4);
    out_ready = 1'b1;
    tick();
    check("t4_ready_after_pop", {31'h0, cmd_ready}, 32'h1);
    check("t4_count_after_pop", {29'h0, fifo_count}, 32'h3);
    tick();
    cmd_valid = 1'b0;
    check("t4_push_pop_count", {29'h0, fifo_count}, 32'h3);
    wait_drain("t4");

    // addr_load to 0xFF, wrap, and load coinciding with a pop
    do_reset();
    out_ready = 1'b0;
    addr_base = 8'hFF;
    addr_load = 1'b1;
    tick();
    addr_load = 1'b0;
    check("t5_addr_loaded", {24'h0, out_addr}, 32'hFF);
    exp_q.push_back('{addr: 8'hFF, data: 32'h00100093});
    exp_q.push_back('{addr: 8'h00, data: 32'h00200113});
    exp_q.push_back('{addr: 8'h40, data: 32'h00300193});
    send(3'b101, 3'b000, 5'd1, 5'd0, 5'd0, 12'h001);
    send(3'b101, 3'b000, 5'd2, 5'd0, 5'd0, 12'h002);
    send(3'b101, 3'b000, 5'd3, 5'd0, 5'd0, 12'h003);
    out_ready = 1'b1;
    tick();
    check("t5_wrap_addr", {24'h0, out_addr}, 32'h00);
    addr_base = 8'h40;
    addr_load = 1'b1;
    tick();
    addr_load = 1'b0;
    check("t5_load_priority", {24'h0, out_addr}, 32'h40);
    check("t5_pop_still", {29'h0, fifo_count}, 32'h1);
    wait_drain("t5");

    // reset with 3 buffered entries discards them
    out_ready = 1'b0;
    send(3'b101, 3'b000, 5'd1, 5'd0, 5'd0, 12'h001);
    send(3'b101, 3'b000, 5'd2, 5'd0, 5'd0, 12'h002);
    send(3'b101, 3'b000, 5'd3, 5'd0, 5'd0, 12'h003);
    check("t6_pre_count", {29'h0, fifo_count}, 32'h3);
    do_reset();
    exp_q.push_back('{addr: 8'h00, data: 32'h00400213});
    send(3'b101, 3'b000, 5'd4, 5'd0, 5'd0, 12'h004);
    check("t6_after_count", {29'h0, fifo_count}, 32'h1);
    out_ready = 1'b1;
    wait_drain("t6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rvne_inst_encoder.md
RVNE_INST_ENCODER -- requirements
Module: rvne_inst_encoder

Interface
REQ-001 SHALL have one clock and asynchronous active-low reset: clk input 1 (all state on rising edge); rst_n input 1 (asynchronous, active-low).
REQ-002 SHALL have the command port: cmd_valid in 1; cmd_ready out 1; cmd_class in 3; cmd_funct3 in 3; cmd_rd in 5; cmd_rs1 in 5; cmd_rs2 in 5; cmd_imm in 12.
REQ-003 SHALL have the output port: out_valid out 1; out_ready in 1; out_addr out 8 (instruction-memory word address); out_data out 32 (encoded instruction).
REQ-004 SHALL have the control/status ports: addr_load in 1; addr_base in 8; err_illegal out 1 (one-cycle pulse); err_count out 8; fifo_count out 3.
REQ-005 SHALL use parameter FIFO_DEPTH, default 4, meaning output buffer entries (power of two, 2..8).

Function
REQ-006 SHALL map cmd_class to opcode: 000 LOAD 0000011, 001 STORE 0100011, 010 NEURON 0000001, 011 RTYPE 0110011, 100 BRANCH 1100011, 101 ITYPE 0010011, 110 VLOAD 0000010, 111 NSR 0110010.
REQ-007 SHALL use I-format for LOAD/ITYPE/VLOAD: imm[11:0] | rs1 | funct3 | rd | opcode.
REQ-008 SHALL use S-format for STORE: imm[11:5] | rs2 | rs1 | funct3 | imm[4:0] | opcode.
REQ-009 SHALL use B-format for BRANCH, with cmd_imm = offset[12:1]: bit31=imm[11], [30:25]=imm[9:4], [24:20]=rs2, [19:15]=rs1, [14:12]=funct3, [11:8]=imm[3:0], bit7=imm[10], [6:0]=opcode.
REQ-010 SHALL use R-format for RTYPE/NEURON/NSR: funct7=imm[11:5] | rs2 | rs1 | funct3 | rd | opcode.
REQ-011 SHALL treat as illegal: VLOAD with funct3 110 or 111; NEURON with funct3 above 010.
REQ-012 SHALL drive cmd_ready = (fifo_count < FIFO_DEPTH), combinationally from registered count only.
REQ-013 SHALL accept a command on a cycle where cmd_valid && cmd_ready; a legal command is encoded combinationally and pushed into the FIFO that same edge.
REQ-014 SHALL discard an illegal accepted command (no push), pulse err_illegal high the following cycle, and increment err_count, saturating at 255.
REQ-015 SHALL drive out_valid = (fifo_count != 0) and out_data = FIFO head; latency from accepting a legal command into an empty FIFO to out_valid is 1 cycle.
REQ-016 SHALL hold out_data and out_addr stable while out_valid && !out_ready.
REQ-017 SHALL, on out_valid && out_ready, pop the head and increment out_addr by 1, wrapping 255 -> 0.
REQ-018 SHALL, on simultaneous push and pop, leave fifo_count unchanged and preserve order; while full, a pop in a cycle only raises cmd_ready the next cycle.
REQ-019 SHALL, on addr_load, set out_addr = addr_base at the next edge; addr_load takes priority over a coincident pop increment, and the pop still occurs.
REQ-020 SHALL preserve FIFO contents across addr_load.

Reset
REQ-021 SHALL, while rst_n = 0, immediately clear: fifo_count 0, out_valid 0, out_addr 0x00, err_illegal 0, err_count 0, FIFO pointers 0; out_data is don't-care while out_valid = 0.
REQ-022 SHALL discard buffered entries on reset mid-operation; the first command accepted after reset release is written at out_addr 0.

Verification
REQ-023 SHALL cover ITYPE, funct3 000, rd 1, rs1 0, imm 0x005 into an empty FIFO -> next cycle out_valid=1, out_data=0x00500093, out_addr=0x00.
REQ-024 SHALL cover STORE, funct3 010, rs1 2, rs2 5, imm 0x008, then VLOAD, funct3 001, rd 2, rs1 3, imm 0x010, with out_ready=1 -> outputs 0x00512423 @0x00, then 0x01019102 @0x01.
REQ-025 SHALL cover NEURON, funct3 011 -> no push, err_illegal pulses 1 cycle, err_count=1; then NSR, funct3 001, rs1 1, rs2 2 -> 0x00209032.
REQ-026 SHALL cover 5 legal commands pushed with out_ready=0 -> cmd_ready low after the 4th, fifo_count=4; raise out_ready -> in-order drain, addresses 0..3, 5th accepted after the first pop.
REQ-027 SHALL cover addr_load, addr_base=0xFF, then 2 pops -> out_addr 0xFF then 0x00; assert rst_n low with 3 entries -> out_valid=0 and fifo_count=0 immediately.
